// File: rtl/ula.sv
// ---------------------------------------------------------------------------
// ula -- registered single-cycle arithmetic/logic unit
//
// Computes one of ten integer operations on two WIDTH-bit operands and
// registers the result. Every rising clock edge loads a new result; there
// is no handshake and no combinational path from inputs to outputs.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (data_out -> 0, zero_out -> 1)
//   data1_in    operand A (value being shifted for shift operations)
//   data2_in    operand B (bits [4:0] give the shift amount for shifts)
//   select_ula  operation select:
//                 0001 ADD  0010 SUB  0011 SLL  0100 SLT  0101 SLTU
//                 0110 SRL  0111 SRA  1000 XOR  1001 OR   1010 AND
//                 any other code yields zero
//   data_out    registered result
//   zero_out    registered "result is zero" flag; exists only when the
//               macro ULA_ZERO_FLAG_EN is defined
//
// Configuration macro: ULA_ZERO_FLAG_EN
// ---------------------------------------------------------------------------
module ula #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data1_in,
    input  logic [WIDTH-1:0] data2_in,
    input  logic [3:0]       select_ula,
    output logic [WIDTH-1:0] data_out
`ifdef ULA_ZERO_FLAG_EN
    ,
    output logic             zero_out
`endif
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SLT  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SRL  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_OR   = 4'b1001,
        OP_AND  = 4'b1010
    } op_t;

    op_t              op;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] result;

    always_comb begin
        op     = op_t'(select_ula);
        // Only the low five bits of B count, so a shift by 32 acts as 0.
        shamt  = data2_in[4:0];
        result = '0;
        case (op)
            OP_ADD:  result = data1_in + data2_in;
            OP_SUB:  result = data1_in - data2_in;
            OP_SLL:  result = data1_in << shamt;
            OP_SLT:  result = {{(WIDTH-1){1'b0}},
                               ($signed(data1_in) < $signed(data2_in))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (data1_in < data2_in)};
            OP_SRL:  result = data1_in >> shamt;
            OP_SRA:  result = $signed(data1_in) >>> shamt;
            OP_XOR:  result = data1_in ^ data2_in;
            OP_OR:   result = data1_in | data2_in;
            OP_AND:  result = data1_in & data2_in;
            default: result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= result;
        end
    end

`ifdef ULA_ZERO_FLAG_EN
    // Reset value 1 matches the reset value 0 held in data_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_out <= 1'b1;
        end else begin
            zero_out <= (result == '0);
        end
    end
`endif

endmodule

// File: tb/tb_ula.sv
// ---------------------------------------------------------------------------
// tb_ula -- self-checking bench for ula
//
// Inputs are driven on the falling edge, outputs sampled 1 time unit after
// the rising edge. Expected values come from an arithmetic reference model
// (powers of two, integer division, signed integer compares).
// Define ULA_ZERO_FLAG_EN for both files to exercise zero_out.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ula;

    logic        clk;
    logic        rst_n;
    logic [31:0] data1_in;
    logic [31:0] data2_in;
    logic [3:0]  select_ula;
    logic [31:0] data_out;
`ifdef ULA_ZERO_FLAG_EN
    logic        zero_out;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    ula #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data1_in   (data1_in),
        .data2_in   (data2_in),
        .select_ula (select_ula),
        .data_out   (data_out)
`ifdef ULA_ZERO_FLAG_EN
        ,
        .zero_out   (zero_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want finish)");
        $fatal(1, "watchdog");
    end

    // Reference model built from arithmetic definitions of each operation.
    function automatic logic [31:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [3:0]  op);
        logic [63:0] pow2;
        logic [63:0] prod;
        logic [31:0] na;
        int          sa;
        int          sb;
        int unsigned sh;
        sh   = b % 32;
        pow2 = 64'd1;
        for (int unsigned i = 0; i < sh; i++) pow2 = pow2 * 64'd2;
        sa   = a;
        sb   = b;
        na   = ~a;
        case (op)
            4'd1:  return a + b;
            4'd2:  return a - b;
            4'd3:  begin prod = a * pow2; return prod[31:0]; end
            4'd4:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd5:  return (a < b) ? 32'd1 : 32'd0;
            4'd6:  return a / pow2;
            // floor division of a negative value: ~(~a / 2^s)
            4'd7:  return a[31] ? ~(na / pow2) : a / pow2;
            4'd8:  return a ^ b;
            4'd9:  return a | b;
            4'd10: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        data1_in   = a;
        data2_in   = b;
        select_ula = op;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(32'h5555_5555, 32'hAAAA_AAAA, 4'd1);
        #1;
        n_checks++;
        if (data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want %h", data_out, 32'd0);
        end
`ifdef ULA_ZERO_FLAG_EN
        n_checks++;
        if (zero_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_zero: got %b want 1", zero_out);
        end
`endif
        // Edges under reset must not load the pending ADD result.
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", data_out, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after release loads a normal result.
        @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL reset_first_edge: got %h want %h", data_out, 32'hFFFF_FFFF);
        end
    endtask

    task automatic test_directed;
        logic [31:0] va [12];
        logic [31:0] vb [12];
        logic [3:0]  vo [12];
        logic [31:0] ve [12];
        va = '{32'h5555_5555, 32'h0380_0155, 32'h0380_0155, 32'd4,
               32'h0380_0155, 32'h8000_0000, 32'h0380_0155, 32'h8380_0155,
               32'h0380_0155, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555};
        vb = '{32'hAAAA_AAAA, 32'h0005_5400, 32'd4, 32'h0380_0155,
               32'd4, 32'd1, 32'd4, 32'd4,
               32'h24, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'hAAAA_AAAA};
        vo = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd6, 4'd7,
               4'd6, 4'd8, 4'd9, 4'd10};
        ve = '{32'hFFFF_FFFF, 32'h037A_AD55, 32'h3800_1550, 32'd1,
               32'd0, 32'd1, 32'h0038_0015, 32'hF838_0015,
               32'h0038_0015, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(va[i], vb[i], vo[i]);
            @(posedge clk);
            #1;
            n_checks++;
            if (data_out !== ve[i]) begin
                n_fail++;
                $display("FAIL directed_%0d op=%b a=%h b=%h: got %h want %h",
                         i, vo[i], va[i], vb[i], data_out, ve[i]);
            end
`ifdef ULA_ZERO_FLAG_EN
            n_checks++;
            if (zero_out !== (ve[i] == 32'd0)) begin
                n_fail++;
                $display("FAIL directed_zero_%0d: got %b want %b",
                         i, zero_out, (ve[i] == 32'd0));
            end
`endif
        end
        // Unused codes all give zero.
        for (int op = 0; op < 16; op++) begin
            if (op >= 1 && op <= 10) continue;
            @(negedge clk);
            drive(32'hDEAD_BEEF, 32'h1234_5678, op[3:0]);
            @(posedge clk);
            #1;
            n_checks++;
            if (data_out !== 32'd0) begin
                n_fail++;
                $display("FAIL unused_op_%0d: got %h want %h", op, data_out, 32'd0);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
        for (int i = 0; i < 400; i++) begin
            a  = $urandom;
            b  = $urandom;
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: b = a;                                  // equal operands
                1: b = 32'($urandom_range(0, 63));         // small / >=32 shifts
                2: a = {1'b1, 31'($urandom)};              // negative A
                default: ;
            endcase
            exp = model(a, b, op);
            @(negedge clk);
            drive(a, b, op);
            @(posedge clk);
            #1;
            n_checks++;
            if (data_out !== exp) begin
                n_fail++;
                $display("FAIL random_%0d op=%b a=%h b=%h: got %h want %h",
                         i, op, a, b, data_out, exp);
            end
`ifdef ULA_ZERO_FLAG_EN
            n_checks++;
            if (zero_out !== (exp == 32'd0)) begin
                n_fail++;
                $display("FAIL random_zero_%0d: got %b want %b", i, zero_out, (exp == 32'd0));
            end
`endif
        end
    endtask

    // Operation changes every cycle; outputs must hold between edges even
    // when the inputs move mid-cycle.
    task automatic test_back_to_back;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        for (int op = 1; op <= 10; op++) begin
            a   = $urandom;
            b   = $urandom_range(0, 40);
            exp = model(a, b, op[3:0]);
            drive(a, b, op[3:0]);
            @(posedge clk);
            #1;
            n_checks++;
            if (data_out !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h want %h", op, data_out, exp);
            end
            #2;
            drive(~a, b + 32'd7, 4'(op + 3));
            #1;
            n_checks++;
            if (data_out !== exp) begin
                n_fail++;
                $display("FAIL b2b_hold_%0d: got %h want %h", op, data_out, exp);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(32'h5555_5555, 32'hAAAA_AAAA, 4'd9);
        @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL areset_pre: got %h want %h", data_out, 32'hFFFF_FFFF);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_async: got %h want %h", data_out, 32'd0);
        end
`ifdef ULA_ZERO_FLAG_EN
        n_checks++;
        if (zero_out !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_zero: got %b want 1", zero_out);
        end
`endif
        @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 32'd0) begin
            n_fail++;
            $display("FAIL areset_discard: got %h want %h", data_out, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h0380_0155, 32'd4, 4'd3);
        @(posedge clk);
        #1;
        n_checks++;
        if (data_out !== 32'h3800_1550) begin
            n_fail++;
            $display("FAIL areset_release: got %h want %h", data_out, 32'h3800_1550);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        data1_in   = '0;
        data2_in   = '0;
        select_ula = '0;
        test_reset();
        test_directed();
        test_random();
        @(negedge clk);
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
